// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: owns the 128x64 dual-half graphic LCD write bus. Runs the
// panel reset + init sequence, then shares the bus between req0 (renderer)
// and req1 (overlay), producing SETUP / EN / HOLD timing for every word.
// Build option: define LCD_ARB_FIXED_PRIO_EN to make req0 always win when
// both request (req1 may starve); default build arbitrates round-robin.
module lcd_bus_arbiter #(
   parameter int unsigned RST_CYC = 4,
   parameter int unsigned EN_CYC  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       di0,
   input  logic       di1,
   input  logic [1:0] cs0,
   input  logic [1:0] cs1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       init_done,
   output logic [7:0] lcd_data,
   output logic       lcd_en,
   output logic       lcd_rw,
   output logic       lcd_rstn,
   output logic       lcd_cs1,
   output logic       lcd_cs2,
   output logic       lcd_di
);

   localparam int unsigned CNT_MAX = (RST_CYC > EN_CYC) ? RST_CYC : EN_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [7:0] INIT_DISP_ON    = 8'h3F;
   localparam logic [7:0] INIT_START_LINE = 8'hC0;

   typedef enum logic [2:0] {
      ST_RST_HOLD,
      ST_INIT_LOAD,
      ST_SETUP,
      ST_EN_HI,
      ST_HOLD,
      ST_IDLE
   } state_t;

   // Word presented on the LCD pins: cs[0] selects left half, cs[1] right half.
   typedef struct packed {
      logic       di;
      logic [1:0] cs;
      logic [7:0] data;
   } payload_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   payload_t         bus_q;
   logic             en_q;
   logic             rstn_q;
   logic             ack0_q;
   logic             ack1_q;
   logic             init_done_q;
   logic             init_idx_q;
   logic             gnt1_q;
`ifndef LCD_ARB_FIXED_PRIO_EN
   logic             rr_q;
`endif

   logic             gnt1_c;
   payload_t         pay0_c;
   payload_t         pay1_c;
   payload_t         pay_sel_c;

   assign pay0_c    = '{di: di0, cs: cs0, data: data0};
   assign pay1_c    = '{di: di1, cs: cs1, data: data1};
   assign pay_sel_c = gnt1_c ? pay1_c : pay0_c;

   // Grant selection for the current IDLE cycle (1 = req1 wins).
   always_comb begin
      gnt1_c = req1;
      if (req0 && req1) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
         gnt1_c = 1'b0;
`else
         gnt1_c = rr_q;
`endif
      end
   end

   // Sequencer: reset hold, two init words, then arbitrated user transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RST_HOLD;
         cnt_q       <= '0;
         bus_q       <= '0;
         en_q        <= 1'b0;
         rstn_q      <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         init_done_q <= 1'b0;
         init_idx_q  <= 1'b0;
         gnt1_q      <= 1'b0;
`ifndef LCD_ARB_FIXED_PRIO_EN
         rr_q        <= 1'b0;
`endif
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            ST_RST_HOLD: begin
               if (cnt_q == CNT_W'(RST_CYC)) begin
                  rstn_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_INIT_LOAD;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_INIT_LOAD: begin
               bus_q.data <= init_idx_q ? INIT_START_LINE : INIT_DISP_ON;
               bus_q.di   <= 1'b0;
               bus_q.cs   <= 2'b11;
               state_q    <= ST_SETUP;
            end
            ST_SETUP: begin
               en_q    <= 1'b1;
               cnt_q   <= CNT_W'(1);
               state_q <= ST_EN_HI;
            end
            ST_EN_HI: begin
               if (cnt_q == CNT_W'(EN_CYC)) begin
                  en_q    <= 1'b0;
                  state_q <= ST_HOLD;
                  // Init words are never acknowledged.
                  ack0_q  <= init_done_q & ~gnt1_q;
                  ack1_q  <= init_done_q & gnt1_q;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (!init_done_q && !init_idx_q) begin
                  init_idx_q <= 1'b1;
                  state_q    <= ST_INIT_LOAD;
               end else begin
                  init_done_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (req0 || req1) begin
                  gnt1_q  <= gnt1_c;
                  bus_q   <= pay_sel_c;
`ifndef LCD_ARB_FIXED_PRIO_EN
                  rr_q    <= ~gnt1_c;
`endif
                  state_q <= ST_SETUP;
               end
            end
            default: begin
               state_q <= ST_RST_HOLD;
            end
         endcase
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign init_done = init_done_q;
   assign lcd_data  = bus_q.data;
   assign lcd_di    = bus_q.di;
   assign lcd_cs1   = bus_q.cs[0];
   assign lcd_cs2   = bus_q.cs[1];
   assign lcd_en    = en_q;
   assign lcd_rstn  = rstn_q;
   assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: randomized requesters feed a scoreboard; a negedge
// monitor predicts winner, ack cycle and bus payload for every ack pulse.
module tb_lcd_bus_arbiter;

   localparam int RST_CYC  = 4;
   localparam int EN_CYC   = 2;
   localparam int XF       = EN_CYC + 3;
   localparam int LAT      = EN_CYC + 2;
   localparam int INIT_END = RST_CYC + 1 + 2 * XF;
   localparam int TIMEOUT  = 400;
   localparam int NONE     = 32'h7fffffff;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1, di0, di1;
   logic [1:0] cs0, cs1;
   logic [7:0] data0, data1;
   logic       ack0, ack1, init_done;
   logic [7:0] lcd_data;
   logic       lcd_en, lcd_rw, lcd_rstn, lcd_cs1, lcd_cs2, lcd_di;

   typedef struct {
      logic [7:0] data;
      logic       di;
      logic [1:0] cs;
      int         raise;
   } xfer_t;

   xfer_t q0[$];
   xfer_t q1[$];
   int    cyc = 0;
   int    checks = 0;
   int    failures = 0;
   int    free_cyc = 0;
   int    rr_m = 0;

   lcd_bus_arbiter #(.RST_CYC(RST_CYC), .EN_CYC(EN_CYC)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .di0(di0), .di1(di1),
      .cs0(cs0), .cs1(cs1), .data0(data0), .data1(data1),
      .ack0(ack0), .ack1(ack1), .init_done(init_done),
      .lcd_data(lcd_data), .lcd_en(lcd_en), .lcd_rw(lcd_rw), .lcd_rstn(lcd_rstn),
      .lcd_cs1(lcd_cs1), .lcd_cs2(lcd_cs2), .lcd_di(lcd_di)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected pin state k cycles after reset release during the init sequence.
   function automatic logic [16:0] exp_init(input int k);
      logic       rstn, en, done;
      logic [7:0] d;
      logic [1:0] cs;
      rstn = (k > RST_CYC);
      done = (k >= INIT_END);
      en   = 1'b0;
      d    = 8'h00;
      cs   = 2'b00;
      for (int j = 0; j < 2; j++) begin
         int s = RST_CYC + 1 + j * XF;
         if (k >= s + 1) begin
            d  = (j == 0) ? 8'h3F : 8'hC0;
            cs = 2'b11;
         end
         if (k >= s + 2 && k <= s + 1 + EN_CYC) en = 1'b1;
      end
      return {rstn, en, d, cs[0], cs[1], 1'b0, done, 2'b00, 1'b0};
   endfunction

   task automatic set_req(input int id, input logic r, input logic [7:0] d,
                          input logic di, input logic [1:0] cs);
      if (id == 0) begin
         req0 = r; data0 = d; di0 = di; cs0 = cs;
      end else begin
         req1 = r; data1 = d; di1 = di; cs1 = cs;
      end
   endtask

   // Wait for this requester's ack, then drop req the cycle after it.
   task automatic finish_pending(input int id, input bit scramble);
      int n = 0;
      bit got = 1'b0;
      while (!got && n < TIMEOUT) begin
         @(posedge clk); #1;
         n++;
         if (scramble && lcd_en) data0 = 8'h22;
         got = (id == 0) ? ack0 : ack1;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL ack_timeout req%0d: no ack within %0d cycles", id, TIMEOUT);
      end
      @(posedge clk); #1;
      if (id == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   task automatic xfer(input int id, input logic [7:0] d, input logic di,
                       input logic [1:0] cs, input bit scramble);
      xfer_t e;
      set_req(id, 1'b1, d, di, cs);
      e = '{data: d, di: di, cs: cs, raise: cyc};
      if (id == 0) q0.push_back(e); else q1.push_back(e);
      finish_pending(id, scramble);
   endtask

   task automatic drive(input int id, input int n, input int gap_max);
      for (int i = 0; i < n; i++) begin
         int gap = $urandom_range(gap_max, 0);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
         xfer(id, 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)),
              2'($urandom_range(3, 0)), 1'b0);
      end
   endtask

   // Reset for 3 cycles, then step through the init sequence cycle by cycle.
   task automatic reset_and_init(input bit pend1);
      xfer_t e;
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clk); #1;
      check("reset_values", {lcd_rstn, lcd_en, lcd_data, lcd_cs1, lcd_cs2, lcd_di,
                             init_done, ack0, ack1, lcd_rw}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      q0.delete();
      q1.delete();
      rst = 1'b0;
      for (int k = 1; k <= INIT_END; k++) begin
         @(posedge clk); #1;
         if (pend1 && k == 8) begin
            set_req(1, 1'b1, 8'h5A, 1'b1, 2'b10);
            e = '{data: 8'h5A, di: 1'b1, cs: 2'b10, raise: cyc};
            q1.push_back(e);
         end
         check($sformatf("init_k%0d", k),
               {lcd_rstn, lcd_en, lcd_data, lcd_cs1, lcd_cs2, lcd_di,
                init_done, ack0, ack1, lcd_rw}, exp_init(k));
      end
      free_cyc = cyc;
      rr_m     = 0;
   endtask

   // Monitor: predict grant from pending requests and bus availability.
   always @(negedge clk) begin : monitor
      int    r0, r1, tstar, exp_id, act_id;
      xfer_t e;
      if (!rst && (ack0 || ack1)) begin
         check("ack_not_both", 64'(ack0 & ack1), 64'd0);
         act_id = ack1 ? 1 : 0;
         r0 = (q0.size() > 0) ? q0[0].raise : NONE;
         r1 = (q1.size() > 0) ? q1[0].raise : NONE;
         check("ack_expected", 64'((act_id == 1) ? (q1.size() > 0) : (q0.size() > 0)), 64'd1);
         if ((act_id == 0 && q0.size() > 0) || (act_id == 1 && q1.size() > 0)) begin
            tstar = (r0 < r1) ? r0 : r1;
            if (free_cyc > tstar) tstar = free_cyc;
            if (r0 <= tstar && r1 <= tstar) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
               exp_id = 0;
`else
               exp_id = rr_m;
`endif
            end else begin
               exp_id = (r1 <= tstar) ? 1 : 0;
            end
            check("arb_winner", 64'(act_id), 64'(exp_id));
            check("ack_cycle", 64'(cyc), 64'(tstar + LAT));
            if (act_id == 1) e = q1.pop_front(); else e = q0.pop_front();
            check("bus_payload",
                  {lcd_di, lcd_cs2, lcd_cs1, lcd_data, lcd_en, lcd_rw, init_done},
                  {e.di, e.cs[1], e.cs[0], e.data, 1'b0, 1'b0, 1'b1});
            rr_m     = 1 - act_id;
            free_cyc = cyc + 1;
         end
      end
   end

   initial begin
      rst = 1'b1;
      set_req(0, 1'b0, 8'h00, 1'b0, 2'b00);
      set_req(1, 1'b0, 8'h00, 1'b0, 2'b00);

      // Power-up sequence.
      reset_and_init(1'b0);

      // Single directed writes, including a transfer with no half selected.
      xfer(0, 8'hA5, 1'b1, 2'b01, 1'b0);
      xfer(1, 8'h3C, 1'b0, 2'b00, 1'b0);

      // Both requesters held continuously.
      fork
         drive(0, 6, 0);
         drive(1, 6, 0);
      join

      // Random traffic.
      fork
         drive(0, 25, 3);
         drive(1, 25, 3);
      join

      // Payload change during EN_HI must not reach the bus.
      xfer(0, 8'h11, 1'b1, 2'b11, 1'b1);

      // Reset in the middle of an enable pulse, with req1 raised during init.
      set_req(0, 1'b1, 8'h77, 1'b0, 2'b11);
      begin : wait_en
         int n = 0;
         while (!lcd_en && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
         end
         check("reach_en_hi", 64'(lcd_en), 64'd1);
      end
      reset_and_init(1'b1);
      finish_pending(1, 1'b0);

      // More random traffic after the second init.
      fork
         drive(0, 5, 3);
         drive(1, 5, 3);
      join

      repeat (8) @(posedge clk);
      #1;
      check("sb_drain", 64'(q0.size() + q1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
